bin_to_bcd_seq: RTL

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that sits between the processor's 16-bit result bus and the seven-segment display driver. It replaces per-digit divide/modulo logic with a small iterative datapath. It accepts a binary value on a start strobe and returns five packed BCD digits after a fixed latency. The result is held stable between conversions, and a flag marks values that do not fit on the 4-digit display.

---
 rtl/bin_to_bcd_seq_pkg.sv | 14 +
 rtl/bin_to_bcd_seq_digit_adjust.sv | 13 +
 rtl/bin_to_bcd_seq.sv | 115 +++++++++++
 3 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state type, default widths and BCD digit width.
package bin_to_bcd_seq_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int unsigned DEF_W  = 16;
  localparam int unsigned DEF_ND = 5;
  localparam int unsigned BCD_DW = 4;

endpackage

// File: rtl/bin_to_bcd_seq_digit_adjust.sv
// Per-digit add-3 correction used before each shift of the double-dabble datapath.
module bcd_digit_adjust (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  // Inputs 10..15 never occur; they wrap mod 16, which keeps the result deterministic.
  always_comb begin
    d_o = d_i;
    if (d_i >= 4'd5) d_o = d_i + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter: shift-and-add-3, one bit per clock,
// result and overflow flag held until the next conversion completes.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int unsigned W  = DEF_W,
  parameter int unsigned ND = DEF_ND
) (
  input  logic                 clk_100mhz,
  input  logic                 reset,
  input  logic                 start,
  input  logic [W-1:0]         bin_in,
  output logic                 busy,
  output logic                 done,
  output logic [ND*BCD_DW-1:0] bcd_out,
  output logic                 over_9999
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned BW = ND * BCD_DW;
  localparam int unsigned DISP_BITS = 4 * BCD_DW;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [W-1:0]    bin_q, bin_d;
  logic [BW-1:0]   out_q, out_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [BW-1:0]   adj;
  logic [BW-1:0]   shifted_bcd;
  logic            ovf_next;

  for (genvar g = 0; g < ND; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d_i (bcd_q[g*BCD_DW +: BCD_DW]),
      .d_o (adj[g*BCD_DW +: BCD_DW])
    );
  end

  // Post-shift BCD field: adjusted digits shifted left, binary MSB enters at bit 0.
  assign shifted_bcd = {adj[BW-2:0], bin_q[W-1]};

  if (ND > 4) begin : g_ovf
    assign ovf_next = |shifted_bcd[BW-1:DISP_BITS];
  end else begin : g_no_ovf
    assign ovf_next = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d   = '0;
          bin_d   = bin_in;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = shifted_bcd;
        bin_d = {bin_q[W-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          out_d   = shifted_bcd;
          ovf_d   = ovf_next;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign bcd_out   = out_q;
  assign over_9999 = ovf_q;

endmodule
